// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first, valid/ready on both sides.
// Optional macro SERIAL_ADDSUB_CARRY_IN_EN adds a cin port used as the initial carry/borrow.
module serial_addsub_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
`ifdef SERIAL_ADDSUB_CARRY_IN_EN
    input  logic             cin,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : gBadParams
            $error("serial_addsub_unit: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT state;
    stateT nextState;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             subOp;
    logic             chainBit;
    logic [CW-1:0]    digitCnt;

    logic [DIGIT-1:0] aDigit;
    logic [DIGIT-1:0] bDigit;
    logic [DIGIT-1:0] digitOut;
    logic             ripple;
    logic             chainNext;
    logic [WIDTH-1:0] nextResult;
    logic             lastDigit;
    logic             overflowNext;
    logic             initChain;

`ifdef SERIAL_ADDSUB_CARRY_IN_EN
    assign initChain = cin;
`else
    assign initChain = 1'b0;
`endif

    assign lastDigit = (digitCnt == LAST_DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        start_ready = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (lastDigit) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Select the active digit, ripple it through DIGIT cells and merge it into the result image.
    always_comb begin
        aDigit     = '0;
        bDigit     = '0;
        digitOut   = '0;
        nextResult = result;
        ripple     = chainBit;
        for (int k = 0; k < N; k++) begin
            if (digitCnt == CW'(k)) begin
                aDigit = opA[k*DIGIT +: DIGIT];
                bDigit = opB[k*DIGIT +: DIGIT];
            end
        end
        for (int j = 0; j < DIGIT; j++) begin
            digitOut[j] = aDigit[j] ^ bDigit[j] ^ ripple;
            if (subOp) begin
                ripple = (~(aDigit[j] ^ bDigit[j]) & ripple) | (~aDigit[j] & bDigit[j]);
            end else begin
                ripple = (aDigit[j] & bDigit[j]) | (ripple & (aDigit[j] ^ bDigit[j]));
            end
        end
        chainNext = ripple;
        for (int k = 0; k < N; k++) begin
            if (digitCnt == CW'(k)) begin
                nextResult[k*DIGIT +: DIGIT] = digitOut;
            end
        end
    end

    always_comb begin
        if (subOp) begin
            overflowNext = (opA[WIDTH-1] != opB[WIDTH-1]) && (nextResult[WIDTH-1] != opA[WIDTH-1]);
        end else begin
            overflowNext = (opA[WIDTH-1] == opB[WIDTH-1]) && (nextResult[WIDTH-1] != opA[WIDTH-1]);
        end
    end

    // Operand latch, digit sequencing and flag capture on the final digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA       <= '0;
            opB       <= '0;
            subOp     <= 1'b0;
            chainBit  <= 1'b0;
            digitCnt  <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        opA      <= op_a;
                        opB      <= op_b;
                        subOp    <= sub;
                        chainBit <= initChain;
                        digitCnt <= '0;
                    end
                end
                RUN: begin
                    result   <= nextResult;
                    chainBit <= chainNext;
                    if (lastDigit) begin
                        digitCnt  <= '0;
                        carry_out <= chainNext;
                        overflow  <= overflowNext;
                        zero      <= (nextResult == '0);
                        res_valid <= 1'b1;
                    end else begin
                        digitCnt <= digitCnt + CW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
